// File: rtl/draw_rect_ctl_pkg.sv
// Shared screen geometry, derived limits and FSM encoding for the draggable rectangle.
package draw_rect_ctl_pkg;

    localparam int DEF_SCREEN_W = 800;
    localparam int DEF_SCREEN_H = 600;
    localparam int DEF_RECT_W   = 48;
    localparam int DEF_RECT_H   = 64;
    localparam int DEF_ACCEL    = 1;
    localparam int DEF_VMAX     = 16;

    // Lowest top-left Y that keeps the rectangle fully on screen.
    localparam int DEF_FLOOR    = DEF_SCREEN_H - DEF_RECT_H;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        FOLLOW = 2'b01,
        FALL   = 2'b10
    } state_t;

    // Clamp a 12-bit unsigned coordinate to an upper limit.
    function automatic logic [11:0] clamp12(input logic [11:0] val, input logic [11:0] lim);
        return (val > lim) ? lim : val;
    endfunction

endpackage

// File: rtl/draw_rect_ctl_edge_detect.sv
// Rising-edge detector: one-cycle pulse on the cycle a level goes from 0 to 1.
module edge_detect (
    input  logic pclk,
    input  logic rst,
    input  logic sig,
    output logic pulse
);

    logic sig_d_reg;

    always_ff @(posedge pclk) begin
        if (rst) begin
            sig_d_reg <= 1'b0;
        end else begin
            sig_d_reg <= sig;
        end
    end

    assign pulse = sig & ~sig_d_reg;

endmodule

// File: rtl/draw_rect_ctl.sv
// Rectangle controller: idle, follow the mouse while held, fall with gravity when released.
module draw_rect_ctl
    import draw_rect_ctl_pkg::*;
#(
    parameter int SCREEN_W = DEF_SCREEN_W,
    parameter int SCREEN_H = DEF_SCREEN_H,
    parameter int RECT_W   = DEF_RECT_W,
    parameter int RECT_H   = DEF_RECT_H,
    parameter int ACCEL    = DEF_ACCEL,
    parameter int VMAX     = DEF_VMAX
) (
    input  logic        pclk,
    input  logic        rst,
    input  logic [11:0] mouse_xpos,
    input  logic [11:0] mouse_ypos,
    input  logic        mouse_left,
    input  logic        rect_clicked,
    input  logic        vblnk,
    output logic [11:0] xpos,
    output logic [11:0] ypos,
    output logic        grabbed,
    output logic        falling
);

    localparam logic [11:0] X_MAX   = 12'(SCREEN_W - RECT_W);
    localparam logic [11:0] Y_MAX   = 12'(SCREEN_H - RECT_H);
    localparam logic [12:0] FLOOR13 = 13'(SCREEN_H - RECT_H);

    state_t      state_reg, state_next;
    logic [11:0] xpos_next, ypos_next;
    logic [4:0]  vel_reg, vel_next;
    logic        tick;
    logic [5:0]  vel_inc;
    logic [4:0]  vel_step;
    logic [12:0] fall_sum;

    edge_detect u_vblnk_edge (
        .pclk  (pclk),
        .rst   (rst),
        .sig   (vblnk),
        .pulse (tick)
    );

    // Fall arithmetic is one bit wider than its operands so nothing wraps.
    assign vel_inc  = {1'b0, vel_reg} + 6'(ACCEL);
    assign vel_step = (vel_inc > 6'(VMAX)) ? 5'(VMAX) : vel_inc[4:0];
    assign fall_sum = {1'b0, ypos} + {8'd0, vel_step};

    always_comb begin
        state_next = state_reg;
        xpos_next  = xpos;
        ypos_next  = ypos;
        vel_next   = vel_reg;
        case (state_reg)
            IDLE: begin
                if (rect_clicked && mouse_left) begin
                    state_next = FOLLOW;
                end
            end
            FOLLOW: begin
                // Release wins over a coincident frame tick.
                if (!mouse_left) begin
                    state_next = FALL;
                    vel_next   = 5'd0;
                end else if (tick) begin
                    xpos_next = clamp12(mouse_xpos, X_MAX);
                    ypos_next = clamp12(mouse_ypos, Y_MAX);
                end
            end
            FALL: begin
                // Regrab wins over a coincident fall step.
                if (rect_clicked && mouse_left) begin
                    state_next = FOLLOW;
                    vel_next   = 5'd0;
                end else if (tick) begin
                    if (fall_sum >= FLOOR13) begin
                        ypos_next  = Y_MAX;
                        vel_next   = 5'd0;
                        state_next = IDLE;
                    end else begin
                        ypos_next = fall_sum[11:0];
                        vel_next  = vel_step;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            state_reg <= IDLE;
            xpos      <= 12'd0;
            ypos      <= 12'd0;
            vel_reg   <= 5'd0;
            grabbed   <= 1'b0;
            falling   <= 1'b0;
        end else begin
            state_reg <= state_next;
            xpos      <= xpos_next;
            ypos      <= ypos_next;
            vel_reg   <= vel_next;
            grabbed   <= (state_next == FOLLOW);
            falling   <= (state_next == FALL);
        end
    end

endmodule

// File: tb/tb_draw_rect_ctl.sv
// Directed bench for draw_rect_ctl: grab, clamp, fall, release/regrab priority and reset abort.
module tb_draw_rect_ctl;

    logic        pclk = 1'b0;
    logic        rst;
    logic [11:0] mouse_xpos, mouse_ypos;
    logic        mouse_left, rect_clicked, vblnk;
    logic [11:0] xpos, ypos;
    logic        grabbed, falling;

    int vectors = 0;
    int miscompares = 0;

    draw_rect_ctl dut (
        .pclk         (pclk),
        .rst          (rst),
        .mouse_xpos   (mouse_xpos),
        .mouse_ypos   (mouse_ypos),
        .mouse_left   (mouse_left),
        .rect_clicked (rect_clicked),
        .vblnk        (vblnk),
        .xpos         (xpos),
        .ypos         (ypos),
        .grabbed      (grabbed),
        .falling      (falling)
    );

    always #5 pclk = ~pclk;

    task automatic step();
        @(posedge pclk);
        #1;
    endtask

    // One vblnk pulse: exactly one tick lands on the first edge.
    task automatic frame_tick();
        vblnk = 1'b1;
        step();
        vblnk = 1'b0;
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1; mouse_xpos = 12'd0; mouse_ypos = 12'd0;
        mouse_left = 1'b0; rect_clicked = 1'b0; vblnk = 1'b0;
        step(); step();
        rst = 1'b0;
        vectors++;
        if (xpos !== 12'd0 || ypos !== 12'd0 || grabbed !== 1'b0 || falling !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_state: got x=%0d y=%0d g=%b f=%b, need 0 0 0 0", xpos, ypos, grabbed, falling);
        end
        $display("reset: x=%0d y=%0d g=%b f=%b", xpos, ypos, grabbed, falling);
    endtask

    task automatic test_grab();
        rect_clicked = 1'b1; mouse_left = 1'b1; mouse_xpos = 12'd300; mouse_ypos = 12'd200;
        step();
        rect_clicked = 1'b0;
        vectors++;
        if (grabbed !== 1'b1 || xpos !== 12'd0 || ypos !== 12'd0) begin
            miscompares++;
            $display("FAIL grab_state: got g=%b x=%0d y=%0d, need g=1 x=0 y=0", grabbed, xpos, ypos);
        end
        frame_tick();
        vectors++;
        if (xpos !== 12'd300 || ypos !== 12'd200 || grabbed !== 1'b1) begin
            miscompares++;
            $display("FAIL grab_follow: got x=%0d y=%0d g=%b, need 300 200 1", xpos, ypos, grabbed);
        end
        $display("grab: x=%0d y=%0d g=%b", xpos, ypos, grabbed);
    endtask

    task automatic test_clamp();
        mouse_xpos = 12'd790; mouse_ypos = 12'd590;
        rect_clicked = 1'b1;   // no effect while already following
        frame_tick();
        rect_clicked = 1'b0;
        vectors++;
        if (xpos !== 12'd752 || ypos !== 12'd536 || grabbed !== 1'b1 || falling !== 1'b0) begin
            miscompares++;
            $display("FAIL clamp_790_590: got x=%0d y=%0d g=%b f=%b, need 752 536 1 0", xpos, ypos, grabbed, falling);
        end
        mouse_xpos = 12'd4095; mouse_ypos = 12'd4095;
        frame_tick();
        vectors++;
        if (xpos !== 12'd752 || ypos !== 12'd536) begin
            miscompares++;
            $display("FAIL clamp_4095: got x=%0d y=%0d, need 752 536", xpos, ypos);
        end
        mouse_xpos = 12'd751; mouse_ypos = 12'd535;
        frame_tick();
        vectors++;
        if (xpos !== 12'd751 || ypos !== 12'd535) begin
            miscompares++;
            $display("FAIL clamp_below: got x=%0d y=%0d, need 751 535", xpos, ypos);
        end
        $display("clamp: x=%0d y=%0d", xpos, ypos);
    endtask

    task automatic test_fall();
        mouse_xpos = 12'd100; mouse_ypos = 12'd100;
        frame_tick();
        mouse_left = 1'b0;
        step();
        vectors++;
        if (falling !== 1'b1 || grabbed !== 1'b0 || ypos !== 12'd100 || dut.vel_reg !== 5'd0) begin
            miscompares++;
            $display("FAIL fall_release: got f=%b g=%b y=%0d v=%0d, need 1 0 100 0", falling, grabbed, ypos, dut.vel_reg);
        end
        for (int i = 0; i < 16; i++) frame_tick();
        vectors++;
        if (ypos !== 12'd236 || dut.vel_reg !== 5'd16 || xpos !== 12'd100) begin
            miscompares++;
            $display("FAIL fall_16: got y=%0d v=%0d x=%0d, need 236 16 100", ypos, dut.vel_reg, xpos);
        end
        for (int i = 0; i < 18; i++) frame_tick();
        vectors++;
        if (ypos !== 12'd524 || falling !== 1'b1 || dut.vel_reg !== 5'd16) begin
            miscompares++;
            $display("FAIL fall_34: got y=%0d f=%b v=%0d, need 524 1 16", ypos, falling, dut.vel_reg);
        end
        frame_tick();
        vectors++;
        if (ypos !== 12'd536 || falling !== 1'b0 || grabbed !== 1'b0 || dut.vel_reg !== 5'd0 || xpos !== 12'd100) begin
            miscompares++;
            $display("FAIL fall_land: got y=%0d f=%b g=%b v=%0d x=%0d, need 536 0 0 0 100",
                     ypos, falling, grabbed, dut.vel_reg, xpos);
        end
        // Idle holds position even with button down and ticks running.
        mouse_left = 1'b1; mouse_xpos = 12'd10; mouse_ypos = 12'd10;
        frame_tick(); frame_tick();
        vectors++;
        if (xpos !== 12'd100 || ypos !== 12'd536 || grabbed !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_hold: got x=%0d y=%0d g=%b, need 100 536 0", xpos, ypos, grabbed);
        end
        $display("fall: x=%0d y=%0d f=%b", xpos, ypos, falling);
    endtask

    task automatic test_simultaneous();
        rect_clicked = 1'b1; mouse_left = 1'b1;
        step();
        rect_clicked = 1'b0; mouse_xpos = 12'd200; mouse_ypos = 12'd150;
        frame_tick();
        mouse_xpos = 12'd400; mouse_ypos = 12'd50; mouse_left = 1'b0; vblnk = 1'b1;
        step();
        vblnk = 1'b0;
        vectors++;
        if (falling !== 1'b1 || xpos !== 12'd200 || ypos !== 12'd150 || dut.vel_reg !== 5'd0) begin
            miscompares++;
            $display("FAIL release_tick: got f=%b x=%0d y=%0d v=%0d, need 1 200 150 0", falling, xpos, ypos, dut.vel_reg);
        end
        step();
        $display("simultaneous: x=%0d y=%0d f=%b", xpos, ypos, falling);
    endtask

    task automatic test_regrab();
        rect_clicked = 1'b1; mouse_left = 1'b1;
        step();
        rect_clicked = 1'b0; mouse_xpos = 12'd200; mouse_ypos = 12'd300;
        frame_tick();
        mouse_left = 1'b0;
        step();
        rect_clicked = 1'b1; mouse_left = 1'b1; vblnk = 1'b1;
        step();
        vectors++;
        if (grabbed !== 1'b1 || falling !== 1'b0 || ypos !== 12'd300 || dut.vel_reg !== 5'd0) begin
            miscompares++;
            $display("FAIL regrab_tick: got g=%b f=%b y=%0d v=%0d, need 1 0 300 0", grabbed, falling, ypos, dut.vel_reg);
        end
        rect_clicked = 1'b0; mouse_xpos = 12'd500; mouse_ypos = 12'd400;
        step(); step(); step();
        vectors++;
        if (xpos !== 12'd200 || ypos !== 12'd300 || grabbed !== 1'b1) begin
            miscompares++;
            $display("FAIL held_vblnk: got x=%0d y=%0d g=%b, need 200 300 1", xpos, ypos, grabbed);
        end
        vblnk = 1'b0;
        step();
        $display("regrab: x=%0d y=%0d g=%b", xpos, ypos, grabbed);
    endtask

    task automatic test_reset_mid_fall();
        mouse_left = 1'b0;
        step();
        frame_tick(); frame_tick();
        vectors++;
        if (ypos !== 12'd303 || falling !== 1'b1) begin
            miscompares++;
            $display("FAIL pre_reset_fall: got y=%0d f=%b, need 303 1", ypos, falling);
        end
        rst = 1'b1;
        step();
        vectors++;
        if (xpos !== 12'd0 || ypos !== 12'd0 || grabbed !== 1'b0 || falling !== 1'b0 || dut.vel_reg !== 5'd0) begin
            miscompares++;
            $display("FAIL reset_mid_fall: got x=%0d y=%0d g=%b f=%b v=%0d, need 0 0 0 0 0",
                     xpos, ypos, grabbed, falling, dut.vel_reg);
        end
        step(); step();
        rst = 1'b0;
        step();
        vectors++;
        if (xpos !== 12'd0 || ypos !== 12'd0 || falling !== 1'b0 || grabbed !== 1'b0) begin
            miscompares++;
            $display("FAIL post_reset_idle: got x=%0d y=%0d g=%b f=%b, need 0 0 0 0", xpos, ypos, grabbed, falling);
        end
        $display("reset_mid_fall: x=%0d y=%0d f=%b", xpos, ypos, falling);
    endtask

    initial begin
        test_reset();
        test_grab();
        test_clamp();
        test_fall();
        test_simultaneous();
        test_regrab();
        test_reset_mid_fall();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
